// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - command/response handshake bundle for the accumulator sequencer
interface alu_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_ovf;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ovf
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_ovf
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - accumulator sequencer driving an external 8-bit ALU, with shift-free repeated-add multiply
module alu_seq_ctrl #(
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_ctrl_if.slave    bus,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [1:0]       alu_s,
    input  logic [7:0]       alu_f,
    input  logic             alu_ovf,
    output logic [7:0]       acc,
    output logic             sticky_ovf
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_NOTB = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_CLRF = 3'b111;

    localparam logic [1:0] SEL_ADD  = 2'b00;
    localparam logic [1:0] SEL_NOTB = 2'b01;
    localparam logic [1:0] SEL_AND  = 2'b10;
    localparam logic [1:0] SEL_OR   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q;
    logic [7:0] data_q;
    logic [7:0] count;
    logic [7:0] partial;
    logic [7:0] mcand;
    logic       mul_ovf;
    logic [7:0] rsp_data_q;
    logic       rsp_ovf_q;

    logic       cmd_fire;
    logic       mul_sel;
    logic [7:0] exec_acc;
    logic       exec_ovf;

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_ovf   = rsp_ovf_q;

    assign cmd_fire = bus.cmd_valid && (state_q == IDLE);
    // With the multiplier disabled, opcode 101 falls through EXEC as a READ.
    assign mul_sel  = MUL_EN && (bus.cmd_op == OP_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        alu_a    = acc;
        alu_b    = 8'h00;
        alu_s    = SEL_ADD;
        exec_acc = acc;
        exec_ovf = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = mul_sel ? MUL : EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_LOAD: exec_acc = data_q;
                    OP_ADD: begin
                        alu_b    = data_q;
                        alu_s    = SEL_ADD;
                        exec_acc = alu_f;
                        exec_ovf = alu_ovf;
                    end
                    OP_NOTB: begin
                        alu_b    = data_q;
                        alu_s    = SEL_NOTB;
                        exec_acc = alu_f;
                    end
                    OP_AND: begin
                        alu_b    = data_q;
                        alu_s    = SEL_AND;
                        exec_acc = alu_f;
                    end
                    OP_OR: begin
                        alu_b    = data_q;
                        alu_s    = SEL_OR;
                        exec_acc = alu_f;
                    end
                    default: ;
                endcase
                state_d = RESP;
            end
            MUL: begin
                // One add of the multiplicand per remaining count; a zero count finishes.
                if (count != 8'h00) begin
                    alu_a = partial;
                    alu_b = mcand;
                    alu_s = SEL_ADD;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_LOAD;
            data_q     <= 8'h00;
            acc        <= 8'h00;
            sticky_ovf <= 1'b0;
            rsp_data_q <= 8'h00;
            rsp_ovf_q  <= 1'b0;
            count      <= 8'h00;
            partial    <= 8'h00;
            mcand      <= 8'h00;
            mul_ovf    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        op_q   <= bus.cmd_op;
                        data_q <= bus.cmd_data;
                        if (mul_sel) begin
                            mcand   <= acc;
                            count   <= bus.cmd_data;
                            partial <= 8'h00;
                            mul_ovf <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    acc        <= exec_acc;
                    rsp_data_q <= exec_acc;
                    rsp_ovf_q  <= exec_ovf;
                    if (op_q == OP_CLRF) begin
                        sticky_ovf <= 1'b0;
                    end else if (exec_ovf) begin
                        sticky_ovf <= 1'b1;
                    end
                end
                MUL: begin
                    if (count != 8'h00) begin
                        partial <= alu_f;
                        count   <= count - 8'd1;
                        mul_ovf <= mul_ovf | alu_ovf;
                    end else begin
                        acc        <= partial;
                        rsp_data_q <= partial;
                        rsp_ovf_q  <= mul_ovf;
                        if (mul_ovf) begin
                            sticky_ovf <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl with a behavioural external ALU
module tb_alu_seq_ctrl;

    localparam logic [2:0] LOAD = 3'b000;
    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] NOTB = 3'b010;
    localparam logic [2:0] AND_ = 3'b011;
    localparam logic [2:0] OR_  = 3'b100;
    localparam logic [2:0] MULT = 3'b101;
    localparam logic [2:0] READ = 3'b110;
    localparam logic [2:0] CLRF = 3'b111;

    logic       clk;
    logic       rst_n;
    logic [7:0] alu_a, alu_b, alu_f, acc;
    logic [1:0] alu_s;
    logic       alu_ovf, sticky_ovf;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl #(.MUL_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_f      (alu_f),
        .alu_ovf    (alu_ovf),
        .acc        (acc),
        .sticky_ovf (sticky_ovf)
    );

    // External ALU
    always_comb begin
        alu_f   = 8'h00;
        alu_ovf = 1'b0;
        case (alu_s)
            2'b00: begin
                alu_f   = alu_a + alu_b;
                alu_ovf = (alu_a[7] == alu_b[7]) && (alu_f[7] != alu_a[7]);
            end
            2'b01: alu_f = ~alu_b;
            2'b10: alu_f = alu_a & alu_b;
            default: alu_f = alu_a | alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       ovf;
        logic       st;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each transferred response against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got data 0x%0h, expected no response", bus.rsp_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rsp_data", {24'h0, bus.rsp_data}, {24'h0, e.d});
                check("rsp_ovf", {31'h0, bus.rsp_ovf}, {31'h0, e.ovf});
                check("sticky_ovf", {31'h0, sticky_ovf}, {31'h0, e.st});
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 1, 0);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // Number of rising edges after acceptance until rsp_valid is seen
    task automatic check_latency(input int lat);
        int cyc;
        cyc = 0;
        while (!bus.rsp_valid && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, lat);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 1, 0);
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [7:0] ed,
                        input logic eovf, input logic est, input int lat);
        exp_t e;
        e.d = ed; e.ovf = eovf; e.st = est;
        sbq.push_back(e);
        issue(op, d);
        check_latency(lat);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_acc", {24'h0, acc}, 32'h0);
        check("rst_sticky", {31'h0, sticky_ovf}, 32'h0);
        check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check("rst_rsp_data", {24'h0, bus.rsp_data}, 32'h0);
        check("rst_rsp_ovf", {31'h0, bus.rsp_ovf}, 32'h0);
        check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);

        //    op    data   exp   ovf  sticky lat
        send(LOAD, 8'h07, 8'h07, 1'b0, 1'b0, 1);
        send(ADD,  8'h64, 8'h6B, 1'b0, 1'b0, 1);
        send(LOAD, 8'h50, 8'h50, 1'b0, 1'b0, 1);
        send(ADD,  8'h5A, 8'hAA, 1'b1, 1'b1, 1);
        send(READ, 8'h00, 8'hAA, 1'b0, 1'b1, 1);
        send(CLRF, 8'h00, 8'hAA, 1'b0, 1'b0, 1);
        send(LOAD, 8'h8F, 8'h8F, 1'b0, 1'b0, 1);
        send(AND_, 8'h95, 8'h85, 1'b0, 1'b0, 1);
        send(OR_,  8'h95, 8'h95, 1'b0, 1'b0, 1);
        send(NOTB, 8'h5A, 8'hA5, 1'b0, 1'b0, 1);
        send(ADD,  8'h7F, 8'h24, 1'b0, 1'b0, 1);
        send(LOAD, 8'h05, 8'h05, 1'b0, 1'b0, 1);
        send(MULT, 8'h03, 8'h0F, 1'b0, 1'b0, 4);
        send(LOAD, 8'h40, 8'h40, 1'b0, 1'b0, 1);
        send(MULT, 8'h03, 8'hC0, 1'b1, 1'b1, 4);
        send(MULT, 8'h00, 8'h00, 1'b0, 1'b1, 1);
        send(CLRF, 8'h00, 8'h00, 1'b0, 1'b0, 1);

        // Consumer stall: response must hold and new commands must be refused
        bus.rsp_ready = 1'b0;
        e.d = 8'h33; e.ovf = 1'b0; e.st = 1'b0;
        sbq.push_back(e);
        issue(LOAD, 8'h33);
        check_latency(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = LOAD;
            bus.cmd_data  = 8'hFF;
            check("stall_valid", {31'h0, bus.rsp_valid}, 32'h1);
            check("stall_data", {24'h0, bus.rsp_data}, 32'h33);
            check("stall_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();
        @(negedge clk);
        check("stall_acc", {24'h0, acc}, 32'h33);

        // Reset in the middle of a long multiply
        send(LOAD, 8'h05, 8'h05, 1'b0, 1'b0, 1);
        issue(MULT, 8'h10);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("midmul_rst_acc", {24'h0, acc}, 32'h0);
        check("midmul_rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) check("post_rst_valid", 1, 0);
        end
        check("post_rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
        check("post_rst_acc", {24'h0, acc}, 32'h0);

        send(LOAD, 8'h12, 8'h12, 1'b0, 1'b0, 1);
        send(ADD,  8'hEE, 8'h00, 1'b0, 1'b0, 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
